// File: rtl/led_pattern_sequencer.sv
// -----------------------------------------------------------------------------
// led_pattern_sequencer
//
// Steps through a CPU-programmed table of 8-bit LED patterns and writes each
// one to the LED PIO's s1 slave, one single-cycle write per step, with a
// programmable period between steps. The CPU configures it through a small
// Avalon-MM slave. This block is the only writer of the PIO.
//
// Optional feature macro: LED_SEQ_IRQ_EN
//   defined   -> irq port present, CONTROL[2] is the interrupt enable,
//                irq = done & irq_en (registered)
//   undefined -> no irq port, CONTROL[2] reads 0 and ignores writes
//
// Parameters
//   DEPTH         pattern table entries (power of 2, 2..8)
//   PERIOD_WIDTH  step-period counter width
//
// Ports
//   clk           system clock
//   reset_n       asynchronous active-low reset
//   address       config slave word address
//   chipselect    config slave select
//   write_n       config slave write strobe, active low
//   writedata     config slave write data
//   readdata      config slave read data (combinational, zero wait states)
//   m_chipselect  PIO select
//   m_write_n     PIO write strobe, active low
//   m_address     PIO address, tied to 0
//   m_writedata   PIO data, pattern in [7:0]
//   irq           completion interrupt (LED_SEQ_IRQ_EN only)
//
// Register map
//   0 CONTROL  [0] run, [1] loop, [2] irq_en
//   1 PERIOD   [PERIOD_WIDTH-1:0]
//   2 LENGTH   [3:0], writes of 0 or >DEPTH store DEPTH
//   3 STATUS   [0] busy (RO), [1] done (W1C), [6:4] idx (RO)
//   8+i        PATTERN[i] [7:0]
// -----------------------------------------------------------------------------
module led_pattern_sequencer #(
    parameter int DEPTH        = 8,
    parameter int PERIOD_WIDTH = 24
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        m_chipselect,
    output logic        m_write_n,
    output logic [1:0]  m_address,
    output logic [31:0] m_writedata
`ifdef LED_SEQ_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int         IDX_W   = $clog2(DEPTH);
    localparam logic [3:0] DEPTH_L = 4'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic                    r_run;
    logic                    r_loop;
    logic                    r_done;
    logic [PERIOD_WIDTH-1:0] r_period;
    logic [PERIOD_WIDTH-1:0] r_cnt;
    logic [3:0]              r_length;
    logic [2:0]              r_idx;
    logic [7:0]              r_pattern [DEPTH];
    logic [7:0]              r_last_data;

    logic                    w_wr;
    logic                    w_pat_sel;
    logic [IDX_W-1:0]        w_pat_idx;
    logic [7:0]              w_cur_pattern;
    logic                    w_last_step;
    logic                    w_cnt_zero;
    logic                    w_busy;
    logic                    w_irq_en_bit;
    logic                    w_unused_wdata;

    // ------------------------------------------------------------------
    // Config slave decode
    // ------------------------------------------------------------------
    assign w_wr          = chipselect & ~write_n;
    assign w_pat_sel     = address[3] && (32'(address[2:0]) < DEPTH);
    assign w_pat_idx     = address[IDX_W-1:0];
    assign w_cur_pattern = r_pattern[r_idx[IDX_W-1:0]];
    // LENGTH is compared live, so shrinking it below idx+1 ends the sequence
    // at the next step boundary.
    assign w_last_step   = ({1'b0, r_idx} + 4'd1) >= r_length;
    assign w_cnt_zero    = (r_cnt == '0);
    assign w_busy        = (r_state != S_IDLE);
    assign w_unused_wdata = ^writedata;

    // ------------------------------------------------------------------
    // CPU-visible registers
    // ------------------------------------------------------------------
`ifdef LED_SEQ_IRQ_EN
    logic r_irq_en;
    logic r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && address == 4'd0)
                r_irq_en <= writedata[2];
            r_irq <= r_done & r_irq_en;
        end
    end

    assign w_irq_en_bit = r_irq_en;
    assign irq          = r_irq;
`else
    assign w_irq_en_bit = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_run    <= 1'b0;
            r_loop   <= 1'b0;
            r_done   <= 1'b0;
            r_period <= '0;
            r_length <= DEPTH_L;
            // NOTE: the pattern table is a handful of flops, not a RAM, so it
            // is reset to give the CPU a known table after reset.
            for (int i = 0; i < DEPTH; i++)
                r_pattern[i] <= '0;
        end else begin
            // A CPU CONTROL write in the DONE cycle overrides the auto-clear.
            if (w_wr && address == 4'd0) begin
                r_run  <= writedata[0];
                r_loop <= writedata[1];
            end else if (r_state == S_DONE) begin
                r_run <= 1'b0;
            end

            if (w_wr && address == 4'd1)
                r_period <= writedata[PERIOD_WIDTH-1:0];

            if (w_wr && address == 4'd2) begin
                if (writedata[3:0] == 4'd0 || writedata[3:0] > DEPTH_L)
                    r_length <= DEPTH_L;
                else
                    r_length <= writedata[3:0];
            end

            // Hardware set wins over a same-cycle W1C.
            if (r_state == S_DONE)
                r_done <= 1'b1;
            else if (w_wr && address == 4'd3 && writedata[1])
                r_done <= 1'b0;

            if (w_wr && w_pat_sel)
                r_pattern[w_pat_idx] <= writedata[7:0];
        end
    end

    // NOTE: every combinational output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        readdata = '0;
        if (w_pat_sel) begin
            readdata = {24'b0, r_pattern[w_pat_idx]};
        end else begin
            case (address)
                4'd0:    readdata = {29'b0, w_irq_en_bit, r_loop, r_run};
                4'd1:    readdata = 32'(r_period);
                4'd2:    readdata = {28'b0, r_length};
                4'd3:    readdata = {25'b0, r_idx, 2'b00, r_done, w_busy};
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Sequencer FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    // ------------------------------------------------------------------
    // Sequencer FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:  if (r_run) w_next_state = S_WRITE;
            S_WRITE: w_next_state = r_run ? S_WAIT : S_IDLE;
            S_WAIT: begin
                if (!r_run)
                    w_next_state = S_IDLE;
                else if (w_cnt_zero)
                    w_next_state = (!w_last_step || r_loop) ? S_WRITE : S_DONE;
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Sequencer FSM: outputs (decoded from the state register so that an
    // asynchronous reset drops the strobe without waiting for a clock)
    // ------------------------------------------------------------------
    always_comb begin
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_writedata  = {24'b0, r_last_data};
        if (r_state == S_WRITE) begin
            m_chipselect = 1'b1;
            m_write_n    = 1'b0;
            m_writedata  = {24'b0, w_cur_pattern};
        end
    end

    assign m_address = 2'b00;

    // ------------------------------------------------------------------
    // Step index, period counter and held PIO data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_idx       <= '0;
            r_cnt       <= '0;
            r_last_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_next_state == S_WRITE)
                        r_idx <= '0;
                end
                S_WRITE: begin
                    // PERIOD is sampled here so live edits apply to the next step.
                    r_cnt       <= r_period;
                    r_last_data <= w_cur_pattern;
                end
                S_WAIT: begin
                    if (!w_cnt_zero)
                        r_cnt <= r_cnt - 1'b1;
                    if (w_next_state == S_WRITE)
                        r_idx <= w_last_step ? 3'd0 : r_idx + 3'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
